// File: rtl/bcd_countdown_timer.sv
// Four-digit BCD mm:ss countdown timer driven by synchronized pgt rising edges.
// Digits are shift-loaded from the keypad; done pulses on reaching 00:00.
module bcd_countdown_timer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pgt,
    input  logic       enable,
    input  logic       key_valid,
    input  logic [3:0] key_bcd,
    input  logic       start,
    input  logic       clear,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       zero,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   tick;

    logic [3:0] mt_n, mo_n, st_n, so_n;
    logic       done_n;

    logic [3:0] d_mt, d_mo, d_st, d_so;
    logic       b0, b1, b2;
    logic       dec_zero;

    // Synchronizer runs in every state so a steady-high pgt never ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pgt};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign tick = sync[SYNC_STAGES-1] & ~prev;

    assign zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                  (sec_tens == 4'd0) && (sec_ones == 4'd0);
    assign running = (state == RUN);

    // Seconds tens wraps to 5 on borrow; entered values above 5 just count down.
    always_comb begin
        b0   = (sec_ones == 4'd0);
        d_so = b0 ? 4'd9 : sec_ones - 4'd1;
        d_st = sec_tens;
        if (b0)
            d_st = (sec_tens == 4'd0) ? 4'd5 : sec_tens - 4'd1;
        b1   = b0 && (sec_tens == 4'd0);
        d_mo = min_ones;
        if (b1)
            d_mo = (min_ones == 4'd0) ? 4'd9 : min_ones - 4'd1;
        b2   = b1 && (min_ones == 4'd0);
        d_mt = b2 ? min_tens - 4'd1 : min_tens;
        dec_zero = (d_mt == 4'd0) && (d_mo == 4'd0) &&
                   (d_st == 4'd0) && (d_so == 4'd0);
    end

    always_comb begin
        state_n = state;
        mt_n    = min_tens;
        mo_n    = min_ones;
        st_n    = sec_tens;
        so_n    = sec_ones;
        done_n  = 1'b0;
        if (clear) begin
            state_n = IDLE;
            mt_n    = 4'd0;
            mo_n    = 4'd0;
            st_n    = 4'd0;
            so_n    = 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (!zero)
                            state_n = RUN;
                    end else if (key_valid && key_bcd <= 4'd9) begin
                        mt_n = min_ones;
                        mo_n = sec_tens;
                        st_n = sec_ones;
                        so_n = key_bcd;
                    end
                end
                RUN: begin
                    if (tick && enable && !zero) begin
                        mt_n = d_mt;
                        mo_n = d_mo;
                        st_n = d_st;
                        so_n = d_so;
                        if (dec_zero) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_n = DONE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            min_tens <= mt_n;
            min_ones <= mo_n;
            sec_tens <= st_n;
            sec_ones <= so_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed and randomized bench for bcd_countdown_timer against an
// arithmetic mm:ss model.
module tb_bcd_countdown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pgt = 1'b0;
    logic       enable = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_bcd = 4'd0;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, zero, done;

    int passed = 0;
    int total  = 0;

    // Model: v is the display read as a 4-digit decimal number mmss.
    int v  = 0;
    int ms = 0;  // 0 idle, 1 run, 2 done
    logic exp_done = 1'b0;

    bcd_countdown_timer #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .pgt(pgt), .enable(enable),
        .key_valid(key_valid), .key_bcd(key_bcd),
        .start(start), .clear(clear),
        .min_tens(min_tens), .min_ones(min_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .zero(zero), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".mt"}, 32'(min_tens), 32'((v / 1000) % 10));
        chk({tag, ".mo"}, 32'(min_ones), 32'((v / 100) % 10));
        chk({tag, ".st"}, 32'(sec_tens), 32'((v / 10) % 10));
        chk({tag, ".so"}, 32'(sec_ones), 32'(v % 10));
        chk({tag, ".run"}, 32'(running), 32'(ms == 1));
        chk({tag, ".zero"}, 32'(zero), 32'(v == 0));
        chk({tag, ".done"}, 32'(done), 32'(exp_done));
    endtask

    function automatic int dec(input int x);
        int m, s;
        m = x / 100;
        s = x % 100;
        if (s > 0) s = s - 1;
        else begin
            s = 59;
            m = m - 1;
        end
        return m * 100 + s;
    endfunction

    task automatic key(input int k);
        key_valid = 1'b1;
        key_bcd   = 4'(k);
        step();
        key_valid = 1'b0;
        if (ms == 0 && k <= 9) v = (v * 10 + k) % 10000;
        exp_done = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        if (ms == 0 && v != 0) ms = 1;
        exp_done = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        v = 0;
        ms = 0;
        exp_done = 1'b0;
    endtask

    // One pgt pulse: effect is visible right after the third edge.
    task automatic pulse(input string tag);
        pgt = 1'b1;
        step();
        step();
        step();
        exp_done = 1'b0;
        if (ms == 1 && enable && v != 0) begin
            v = dec(v);
            if (v == 0) begin
                ms = 2;
                exp_done = 1'b1;
            end
        end
        check_all(tag);
        pgt = 1'b0;
        step();
        step();
        step();
        exp_done = 1'b0;
    endtask

    initial begin
        // 1: reset and key entry
        step();
        step();
        rst = 1'b0;
        check_all("reset");
        key(1);
        key(3);
        key(0);
        check_all("keys130");
        key(12);
        check_all("badkey");

        // 2: exact tick latency and done pulse
        do_clear();
        key(2);
        do_start();
        check_all("start2");
        pgt = 1'b1;
        step();
        check_all("lat.e1");
        step();
        check_all("lat.e2");
        step();
        v = 1;
        check_all("lat.e3");
        pgt = 1'b0;
        step();
        step();
        step();
        pgt = 1'b1;
        step();
        step();
        check_all("lat2.e2");
        step();
        v = 0;
        ms = 2;
        exp_done = 1'b1;
        check_all("reach0");
        step();
        exp_done = 1'b0;
        check_all("done1cyc");
        pgt = 1'b0;
        step();
        step();
        step();
        pulse("donehold");

        // 3: borrow chains
        do_clear();
        key(1); key(0); key(0);
        do_start();
        pulse("0100");
        do_clear();
        key(1); key(0); key(0); key(0);
        do_start();
        pulse("1000");
        do_clear();
        key(1); key(9); key(0);
        do_start();
        pulse("0190");

        // 4: pause and held pgt
        do_clear();
        key(1); key(0);
        do_start();
        enable = 1'b0;
        pulse("pause1");
        pulse("pause2");
        pulse("pause3");
        enable = 1'b1;
        pulse("resume");
        pgt = 1'b1;
        for (int i = 0; i < 20; i++) step();
        v = dec(v);
        check_all("held");
        pgt = 1'b0;
        step(); step(); step();

        // 5: start at zero, clear with tick
        do_clear();
        do_start();
        check_all("start0");
        key(5);
        do_start();
        pgt = 1'b1;
        step();
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        v = 0;
        ms = 0;
        check_all("clrtick");
        pgt = 1'b0;
        step(); step(); step();

        // 6: reset mid-run, start beats key
        key(5); key(1); key(7);
        do_start();
        check_all("run0517");
        rst = 1'b1;
        step();
        rst = 1'b0;
        v = 0;
        ms = 0;
        check_all("rstrun");
        key(1); key(2);
        key_valid = 1'b1;
        key_bcd = 4'd3;
        start = 1'b1;
        step();
        key_valid = 1'b0;
        start = 1'b0;
        ms = 1;
        check_all("startwins");

        // randomized operation mix
        do_clear();
        for (int i = 0; i < 200; i++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op < 4) key(int'($urandom_range(0, 15)));
            else if (op < 5) do_start();
            else if (op < 9) begin
                enable = ($urandom_range(0, 3) != 0);
                pulse("rnd.pulse");
            end else if ($urandom_range(0, 3) == 0) do_clear();
            check_all("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
